// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with built-in load-use hazard detection.
// Captures one decoded instruction per cycle. On a load-use dependency it
// holds IF/ID (hazard_stall) and drops a bubble into EX, counting bubbles.
module id_ex_pipe_reg #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_alusrc,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rn,
    output logic [REG_AW-1:0] ex_rm,
    output logic [REG_AW-1:0] ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_alusrc,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              hazard_stall,
    output logic [15:0]       bubble_cnt
);

    // Highest register index is the zero register: writes to it are discarded,
    // so a load targeting it can never feed a dependent instruction.
    localparam logic [REG_AW-1:0] XZR_IDX = {REG_AW{1'b1}};

    logic              valid_q,    valid_d;
    logic [DATA_W-1:0] rd1_q,      rd1_d;
    logic [DATA_W-1:0] rd2_q,      rd2_d;
    logic [DATA_W-1:0] imm_q,      imm_d;
    logic [REG_AW-1:0] rn_q,       rn_d;
    logic [REG_AW-1:0] rm_q,       rm_d;
    logic [REG_AW-1:0] rd_q,       rd_d;
    logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
    logic              alusrc_q,   alusrc_d;
    logic              regwrite_q, regwrite_d;
    logic              memread_q,  memread_d;
    logic [15:0]       bcnt_q,     bcnt_d;

    logic rn_match;
    logic rm_match;
    logic hazard;

    // Load-use detect: a valid load in EX whose destination is read by the
    // instruction in ID. Rm only matters when operand B actually uses rd2.
    always_comb begin
        rn_match = (id_rn == rd_q);
        rm_match = (id_rm == rd_q) && !id_alusrc;
        hazard   = valid_q && memread_q && id_valid && (rd_q != XZR_IDX)
                   && (rn_match || rm_match);
    end

    // Next-state: flush beats hazard bubble beats a normal load from ID.
    // On a bubble the datapath fields are don't-care, so they simply hold.
    always_comb begin
        valid_d    = valid_q;
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        imm_d      = imm_q;
        rn_d       = rn_q;
        rm_d       = rm_q;
        rd_d       = rd_q;
        ctrl_d     = ctrl_q;
        alusrc_d   = alusrc_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        bcnt_d     = bcnt_q;
        if (flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
        end else if (hazard) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            if (bcnt_q != 16'hFFFF) begin
                bcnt_d = bcnt_q + 16'd1;
            end
        end else begin
            valid_d    = id_valid;
            rd1_d      = id_rd1;
            rd2_d      = id_rd2;
            imm_d      = id_imm;
            rn_d       = id_rn;
            rm_d       = id_rm;
            rd_d       = id_rd;
            ctrl_d     = id_ctrl;
            alusrc_d   = id_alusrc;
            regwrite_d = id_regwrite && id_valid;
            memread_d  = id_memread && id_valid;
        end
    end

    // Pipeline register with asynchronous clear of every field.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            rn_q       <= '0;
            rm_q       <= '0;
            rd_q       <= '0;
            ctrl_q     <= '0;
            alusrc_q   <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            bcnt_q     <= 16'd0;
        end else begin
            valid_q    <= valid_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            imm_q      <= imm_d;
            rn_q       <= rn_d;
            rm_q       <= rm_d;
            rd_q       <= rd_d;
            ctrl_q     <= ctrl_d;
            alusrc_q   <= alusrc_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            bcnt_q     <= bcnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_rd1       = rd1_q;
    assign ex_rd2       = rd2_q;
    assign ex_imm       = imm_q;
    assign ex_rn        = rn_q;
    assign ex_rm        = rm_q;
    assign ex_rd        = rd_q;
    assign ex_ctrl      = ctrl_q;
    assign ex_alusrc    = alusrc_q;
    assign ex_regwrite  = regwrite_q;
    assign ex_memread   = memread_q;
    assign hazard_stall = hazard;
    assign bubble_cnt   = bcnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: pass-through, load-use stall, XZR and
// alusrc exemptions, flush priority, bubble counter saturation, async reset.
module tb_id_ex_pipe_reg;

    logic        clk;
    logic        reset_n;
    logic        id_valid;
    logic [63:0] id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rn, id_rm, id_rd;
    logic [7:0]  id_ctrl;
    logic        id_alusrc, id_regwrite, id_memread, flush;
    logic        ex_valid;
    logic [63:0] ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rn, ex_rm, ex_rd;
    logic [7:0]  ex_ctrl;
    logic        ex_alusrc, ex_regwrite, ex_memread, hazard_stall;
    logic [15:0] bubble_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    id_ex_pipe_reg #(.DATA_W(64), .REG_AW(5), .CTRL_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .id_ctrl(id_ctrl),
        .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush), .ex_valid(ex_valid), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd),
        .ex_ctrl(ex_ctrl), .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        $display("check %-24s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                             input logic [4:0] rd, input logic alusrc,
                             input logic regwrite, input logic memread);
        id_valid    = v;
        id_rn       = rn;
        id_rm       = rm;
        id_rd       = rd;
        id_alusrc   = alusrc;
        id_regwrite = regwrite;
        id_memread  = memread;
    endtask

    int hazards;
    int cycles;
    logic [15:0] exp_cnt;

    initial begin
        reset_n = 1'b0;
        flush   = 1'b0;
        id_rd1  = '0; id_rd2 = '0; id_imm = '0; id_ctrl = '0;
        set_instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        check("reset_ex_valid", {63'd0, ex_valid}, 64'd0);
        check("reset_bubble_cnt", {48'd0, bubble_cnt}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Pass-through of a register-immediate ALU op.
        id_rd1 = 64'h1234; id_rd2 = 64'h55; id_imm = 64'h8; id_ctrl = 8'hA5;
        set_instr(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0);
        tick();
        check("pass_ex_rd1", ex_rd1, 64'h1234);
        check("pass_ex_rd2", ex_rd2, 64'h55);
        check("pass_ex_imm", ex_imm, 64'h8);
        check("pass_ex_alusrc", {63'd0, ex_alusrc}, 64'd1);
        check("pass_ex_valid", {63'd0, ex_valid}, 64'd1);
        check("pass_ex_ctrl", {56'd0, ex_ctrl}, 64'hA5);
        check("pass_ex_rd", {59'd0, ex_rd}, 64'd4);
        check("pass_ex_regwrite", {63'd0, ex_regwrite}, 64'd1);

        // Invalid ID loads as a bubble with gated control.
        set_instr(1'b0, 5'd1, 5'd2, 5'd4, 1'b0, 1'b1, 1'b1);
        tick();
        check("inval_ex_valid", {63'd0, ex_valid}, 64'd0);
        check("inval_ex_regwrite", {63'd0, ex_regwrite}, 64'd0);
        check("inval_ex_memread", {63'd0, ex_memread}, 64'd0);

        // Load-use: LDUR X3 in EX, ADD using X3 in ID.
        set_instr(1'b1, 5'd7, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1);
        tick();
        check("ld_ex_memread", {63'd0, ex_memread}, 64'd1);
        set_instr(1'b0, 5'd3, 5'd9, 5'd6, 1'b0, 1'b1, 1'b0);
        #1;
        check("ld_invalid_no_stall", {63'd0, hazard_stall}, 64'd0);
        id_valid = 1'b1;
        #1;
        check("ld_use_stall", {63'd0, hazard_stall}, 64'd1);
        tick();
        check("bubble_ex_valid", {63'd0, ex_valid}, 64'd0);
        check("bubble_ex_regwrite", {63'd0, ex_regwrite}, 64'd0);
        check("bubble_cnt_1", {48'd0, bubble_cnt}, 64'd1);
        check("bubble_no_restall", {63'd0, hazard_stall}, 64'd0);
        tick();
        check("add_ex_valid", {63'd0, ex_valid}, 64'd1);
        check("add_ex_rd", {59'd0, ex_rd}, 64'd6);
        check("add_ex_rn", {59'd0, ex_rn}, 64'd3);
        check("add_bubble_cnt", {48'd0, bubble_cnt}, 64'd1);

        // Load to XZR never stalls.
        set_instr(1'b1, 5'd0, 5'd0, 5'd31, 1'b1, 1'b1, 1'b1);
        tick();
        set_instr(1'b1, 5'd31, 5'd31, 5'd2, 1'b0, 1'b1, 1'b0);
        #1;
        check("xzr_no_stall", {63'd0, hazard_stall}, 64'd0);

        // Load rd=5; rm=5 is ignored when operand B is the immediate.
        set_instr(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1);
        tick();
        set_instr(1'b1, 5'd0, 5'd5, 5'd2, 1'b1, 1'b1, 1'b0);
        #1;
        check("alusrc_no_stall", {63'd0, hazard_stall}, 64'd0);
        id_alusrc = 1'b0;
        #1;
        check("rm_stall", {63'd0, hazard_stall}, 64'd1);

        // Flush together with hazard: flush wins, counter untouched.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_ex_valid", {63'd0, ex_valid}, 64'd0);
        check("flush_bubble_cnt", {48'd0, bubble_cnt}, 64'd1);

        // Flush of a plain valid instruction also kills it.
        set_instr(1'b1, 5'd1, 5'd2, 5'd8, 1'b0, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_plain_valid", {63'd0, ex_valid}, 64'd0);
        check("flush_plain_regwr", {63'd0, ex_regwrite}, 64'd0);

        // Saturation: a self-dependent load held in ID alternates load/bubble.
        set_instr(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1);
        hazards = 0;
        cycles  = 0;
        exp_cnt = 16'd1;
        while (hazards < 32'h10002 && cycles < 32'h30000) begin
            if (hazard_stall) begin
                hazards++;
                exp_cnt = (exp_cnt == 16'hFFFF) ? 16'hFFFF : exp_cnt + 16'd1;
            end
            tick();
            cycles++;
            if (hazards == 100 && !hazard_stall && ex_valid == 1'b0)
                check("sat_cnt_at_100", {48'd0, bubble_cnt}, 64'd101);
        end
        check("sat_hazard_count", 64'(hazards), 64'h10002);
        check("sat_cnt_model", {48'd0, bubble_cnt}, {48'd0, exp_cnt});
        check("sat_cnt_ffff", {48'd0, bubble_cnt}, 64'hFFFF);

        // Mid-stream async reset: outputs clear before any clock edge.
        set_instr(1'b1, 5'd1, 5'd2, 5'd9, 1'b0, 1'b1, 1'b0);
        id_rd1 = 64'hDEAD;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_rst_ex_valid", {63'd0, ex_valid}, 64'd1);
        reset_n = 1'b0;
        #1;
        check("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
        check("rst_ex_rd1", ex_rd1, 64'd0);
        check("rst_ex_regwrite", {63'd0, ex_regwrite}, 64'd0);
        check("rst_bubble_cnt", {48'd0, bubble_cnt}, 64'd0);
        check("rst_ex_rd", {59'd0, ex_rd}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("post_rst_load", ex_rd1, 64'hDEAD);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
